fft_channel_scheduler: RTL and testbench

- Shares the single FFT → |X|² → compare-window → peak-search pipeline between N_CH interferometer channels, one frame at a time.
- Round-robin arbitrates frame-ready requests and streams the winner's sample buffer into the FFT.
- Drives that channel's start_cmp_position into the window selector, waits for the peak result, and returns it tagged with the channel id.

---
 rtl/fft_sched_pkg.sv | 14 +
 rtl/fft_channel_scheduler_rr_arbiter.sv | 25 ++
 rtl/fft_channel_scheduler.sv | 159 +++++++++++++++
 tb/tb_fft_channel_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and defaults for the FFT channel scheduler.
package fft_sched_pkg;
   localparam int FRAME_LEN     = 256;
   localparam int DEF_START_POS = 8;
   localparam int TIMEOUT       = 4096;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

   typedef struct packed {
      logic        timeout;
      logic [7:0]  pos;
      logic [31:0] val;
   } res_t;
endpackage

// File: rtl/fft_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic [N_CH-1:0] gnt,
   output logic [CH_W-1:0] idx,
   output logic            any
);
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      // Walk from the furthest offset down so the nearest requester is written last.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N_CH]) begin
            idx = CH_W'((int'(ptr) + i) % N_CH);
            any = 1'b1;
         end
      end
      gnt[idx] = any;
   end
endmodule

// File: rtl/fft_channel_scheduler.sv
// Time-shares one FFT/peak-search pipeline between N_CH channels, one frame
// at a time, returning each peak result tagged with its channel.
module fft_channel_scheduler #(
   parameter int N_CH          = 4,
   parameter int CH_W          = 2,
   parameter int FRAME_LEN     = fft_sched_pkg::FRAME_LEN,
   parameter int ADDR_W        = 8,
   parameter int RD_LAT        = 1,
   parameter int TIMEOUT       = fft_sched_pkg::TIMEOUT,
   parameter int TO_W          = 13,
   parameter int DEF_START_POS = fft_sched_pkg::DEF_START_POS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   ch_req,
   output logic [N_CH-1:0]   ch_grant,
   output logic [N_CH-1:0]   ch_done,
   output logic              buf_rd_en,
   output logic [ADDR_W-1:0] buf_rd_addr,
   input  logic              fft_ready,
   output logic              fft_in_valid,
   output logic              fft_in_last,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [7:0]        cfg_start_pos,
   output logic [7:0]        start_cmp_position,
   output logic [CH_W-1:0]   frame_ch,
   input  logic              res_valid_in,
   input  logic [7:0]        res_pos_in,
   input  logic [31:0]       res_val_in,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [7:0]        res_pos,
   output logic [31:0]       res_val,
   output logic              res_timeout,
   output logic              busy,
   output logic [7:0]        stray_cnt
);
   import fft_sched_pkg::*;

   state_t                 state, state_nxt;
   logic [N_CH-1:0][7:0]   cfg_reg;
   logic [CH_W-1:0]        rr_ptr;
   logic [N_CH-1:0]        grant_oh;
   logic [ADDR_W-1:0]      addr;
   logic [TO_W-1:0]        to_cnt;
   logic [N_CH-1:0]        arb_gnt;
   logic [CH_W-1:0]        arb_idx;
   logic                   arb_any;
   logic                   start_frame, last_addr, to_hit;
   logic [RD_LAT:1]        vld_pipe, lst_pipe;
   res_t                   res_hold;

   assign last_addr   = (addr == ADDR_W'(FRAME_LEN - 1));
   assign to_hit      = (to_cnt == TO_W'(TIMEOUT - 1));
   assign start_frame = (state == IDLE) && arb_any && fft_ready;
   assign buf_rd_addr = addr;

   rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
      .req (ch_req),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ch_grant  = '0;
      ch_done   = '0;
      buf_rd_en = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:     if (start_frame) state_nxt = STREAM;
         STREAM: begin
            ch_grant  = grant_oh;
            buf_rd_en = 1'b1;
            ch_done   = last_addr ? grant_oh : '0;
            if (last_addr) state_nxt = WAIT_RES;
         end
         WAIT_RES: if (res_valid_in || to_hit) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Start position is captured at grant, so config writes only affect later frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_reg            <= {N_CH{8'(DEF_START_POS)}};
         rr_ptr             <= '0;
         grant_oh           <= '0;
         frame_ch           <= '0;
         start_cmp_position <= 8'(DEF_START_POS);
         addr               <= '0;
         to_cnt             <= '0;
      end else begin
         if (cfg_we && (int'(cfg_ch) < N_CH)) cfg_reg[cfg_ch] <= cfg_start_pos;
         if (start_frame) begin
            grant_oh           <= arb_gnt;
            frame_ch           <= arb_idx;
            start_cmp_position <= cfg_reg[arb_idx];
            rr_ptr             <= (arb_idx == CH_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
         end
         addr   <= (state == STREAM && !last_addr) ? addr + 1'b1 : '0;
         to_cnt <= (state == WAIT_RES) ? to_cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         lst_pipe <= '0;
      end else begin
         vld_pipe[1] <= buf_rd_en;
         lst_pipe[1] <= buf_rd_en && last_addr;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            lst_pipe[i] <= lst_pipe[i-1];
         end
      end
   end

   assign fft_in_valid = vld_pipe[RD_LAT];
   assign fft_in_last  = lst_pipe[RD_LAT];

   // A real result beats a coincident timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_hold  <= '0;
         stray_cnt <= '0;
      end else begin
         res_valid <= 1'b0;
         if (state == WAIT_RES) begin
            if (res_valid_in) begin
               res_valid <= 1'b1;
               res_ch    <= frame_ch;
               res_hold  <= '{timeout: 1'b0, pos: res_pos_in, val: res_val_in};
            end else if (to_hit) begin
               res_valid <= 1'b1;
               res_ch    <= frame_ch;
               res_hold  <= '{timeout: 1'b1, pos: 8'd0, val: 32'd0};
            end
         end else if (res_valid_in && stray_cnt != 8'hFF) begin
            stray_cnt <= stray_cnt + 1'b1;
         end
      end
   end

   assign res_pos     = res_hold.pos;
   assign res_val     = res_hold.val;
   assign res_timeout = res_hold.timeout;
endmodule

// File: tb/tb_fft_channel_scheduler.sv
// Scoreboard bench: expected frames and results are queued as stimulus is driven.
module tb_fft_channel_scheduler;
   localparam int N_CH = 4, CH_W = 2, FRAME_LEN = 256, ADDR_W = 8, TIMEOUT = 4096;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N_CH-1:0] ch_req = '0, ch_grant, ch_done;
   logic buf_rd_en, fft_ready = 1'b0, fft_in_valid, fft_in_last;
   logic [ADDR_W-1:0] buf_rd_addr;
   logic cfg_we = 1'b0;
   logic [CH_W-1:0] cfg_ch = '0, frame_ch, res_ch;
   logic [7:0] cfg_start_pos = '0, start_cmp_position, res_pos_in = '0, res_pos, stray_cnt;
   logic res_valid_in = 1'b0, res_valid, res_timeout, busy;
   logic [31:0] res_val_in = '0, res_val;

   always #5 clk = ~clk;

   fft_channel_scheduler #(
      .N_CH(N_CH), .CH_W(CH_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .RD_LAT(1),
      .TIMEOUT(TIMEOUT), .TO_W(13), .DEF_START_POS(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_grant(ch_grant), .ch_done(ch_done),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .fft_ready(fft_ready),
      .fft_in_valid(fft_in_valid), .fft_in_last(fft_in_last), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_start_pos(cfg_start_pos), .start_cmp_position(start_cmp_position),
      .frame_ch(frame_ch), .res_valid_in(res_valid_in), .res_pos_in(res_pos_in),
      .res_val_in(res_val_in), .res_valid(res_valid), .res_ch(res_ch), .res_pos(res_pos),
      .res_val(res_val), .res_timeout(res_timeout), .busy(busy), .stray_cnt(stray_cnt)
   );

   int checks = 0, errors = 0;

   typedef struct { int ch; int scp; } frm_t;
   typedef struct { int ch; int pos; logic [31:0] val; bit to; } rexp_t;
   frm_t  frm_q[$];
   rexp_t res_q[$];

   // Monitor state (written only by the monitor process)
   bit in_frame = 0, prev_rd = 0, prev_last = 0;
   int exp_addr = 0, vcnt = 0, fbad = 0;
   logic [N_CH-1:0] cur_oh = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 0; prev_rd = 0; prev_last = 0; exp_addr = 0; vcnt = 0; fbad = 0;
         end else begin
            bit now_rd, now_last;
            checks++;
            if (fft_in_valid !== prev_rd || fft_in_last !== prev_last) begin
               errors++;
               $display("FAIL fft_pipe valid=%0b last=%0b expected %0b %0b", fft_in_valid, fft_in_last, prev_rd, prev_last);
            end
            if (fft_in_valid === 1'b1) vcnt++;
            if (fft_in_last === 1'b1) begin
               checks++;
               if (vcnt != FRAME_LEN) begin
                  errors++;
                  $display("FAIL valid_count got %0d expected %0d", vcnt, FRAME_LEN);
               end
               vcnt = 0;
            end
            if (!in_frame && ch_grant !== '0) begin
               frm_t f;
               checks++;
               if (frm_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_grant ch_grant=%b", ch_grant);
                  cur_oh = ch_grant;
               end else begin
                  f = frm_q.pop_front();
                  cur_oh = N_CH'(1) << f.ch;
                  if (ch_grant !== cur_oh || frame_ch !== CH_W'(f.ch) || start_cmp_position !== 8'(f.scp)) begin
                     errors++;
                     $display("FAIL grant got %b ch=%0d scp=%0d expected %b ch=%0d scp=%0d",
                              ch_grant, frame_ch, start_cmp_position, cur_oh, f.ch, f.scp);
                  end
               end
               in_frame = 1; exp_addr = 0; fbad = 0;
            end
            now_rd = in_frame;
            now_last = in_frame && exp_addr == FRAME_LEN - 1;
            if (in_frame) begin
               if (ch_grant !== cur_oh || buf_rd_en !== 1'b1 || buf_rd_addr !== ADDR_W'(exp_addr)) fbad++;
               if (ch_done !== (now_last ? cur_oh : '0)) fbad++;
               if (now_last) begin
                  checks++;
                  if (fbad != 0) begin
                     errors++;
                     $display("FAIL stream %0d bad cycles in frame for grant %b", fbad, cur_oh);
                  end
                  in_frame = 0;
               end
               exp_addr++;
            end else begin
               checks++;
               if (buf_rd_en !== 1'b0 || ch_done !== '0 || ch_grant !== '0) begin
                  errors++;
                  $display("FAIL idle_strobes rd_en=%0b done=%b grant=%b expected 0", buf_rd_en, ch_done, ch_grant);
               end
            end
            prev_rd = now_rd; prev_last = now_last;
            if (res_valid === 1'b1) begin
               rexp_t e;
               checks++;
               if (res_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_res ch=%0d pos=%0d to=%0b", res_ch, res_pos, res_timeout);
               end else begin
                  e = res_q.pop_front();
                  if (res_ch !== CH_W'(e.ch) || res_pos !== 8'(e.pos) || res_val !== e.val || res_timeout !== e.to) begin
                     errors++;
                     $display("FAIL result got ch=%0d pos=%0d val=%h to=%0b expected ch=%0d pos=%0d val=%h to=%0b",
                              res_ch, res_pos, res_val, res_timeout, e.ch, e.pos, e.val, e.to);
                  end
               end
            end
         end
      end
   end

   task automatic wait_wait_res();
      bit ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (busy === 1'b1 && ch_grant === '0) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL wait_res_bound state never reached");
      end
   endtask

   // Drives a peak result in WAIT_RES; returns on the cycle res_valid should be high.
   task automatic send_res(input int ch, input int pos, input logic [31:0] val);
      res_q.push_back('{ch, pos, val, 1'b0});
      res_valid_in = 1'b1; res_pos_in = 8'(pos); res_val_in = val;
      @(negedge clk);
      res_valid_in = 1'b0;
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL res_latency res_valid=%0b expected 1", res_valid);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({ch_grant, ch_done, buf_rd_en, buf_rd_addr, fft_in_valid, fft_in_last, frame_ch,
           res_valid, res_ch, res_pos, res_val, res_timeout, busy, stray_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs grant=%b rd=%0b addr=%0d res_valid=%0b busy=%0b expected all 0",
                  ch_grant, buf_rd_en, buf_rd_addr, res_valid, busy);
      end
      checks++;
      if (start_cmp_position !== 8'd8) begin
         errors++;
         $display("FAIL reset_scp got %0d expected 8", start_cmp_position);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_start_pos = 8'd20;
      @(negedge clk);
      cfg_we = 1'b0; fft_ready = 1'b1;
      frm_q.push_back('{2, 20});
      ch_req = 4'b0100;
      wait_wait_res();
      ch_req = '0;
      send_res(2, 37, 32'h4214_0000);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ch_grant !== '0) begin
         errors++;
         $display("FAIL single_idle busy=%0b grant=%b expected 0 0", busy, ch_grant);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < 5; i++) frm_q.push_back('{i % 4, 8});
      ch_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_wait_res();
         if (i == 4) ch_req = '0;
         send_res(i % 4, 10 + i, 32'h3F80_0000 + 32'(i));
         if (i < 4) begin
            @(negedge clk);
            checks++;
            if (ch_grant !== (N_CH'(1) << ((i + 1) % 4))) begin
               errors++;
               $display("FAIL back_to_back grant=%b expected ch%0d", ch_grant, (i + 1) % 4);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      ch_req = 4'b0001;
      frm_q.push_back('{0, 8});
      wait_wait_res();
      res_q.push_back('{0, 0, 32'd0, 1'b1});
      frm_q.push_back('{0, 8});
      while (n < 5000) begin
         @(negedge clk);
         n++;
         if (res_valid === 1'b1) break;
      end
      checks++;
      if (n != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_latency got %0d cycles expected %0d", n, TIMEOUT);
      end
      @(negedge clk);
      checks++;
      if (ch_grant !== 4'b0001) begin
         errors++;
         $display("FAIL regrant_after_timeout grant=%b expected 0001", ch_grant);
      end
      wait_wait_res();
      ch_req = '0;
      send_res(0, 99, 32'hDEAD_BEEF);
   endtask

   task automatic test_stray_and_cfg();
      bit ok = 0;
      for (int i = 0; i < 3; i++) begin
         res_valid_in = 1'b1;
         @(negedge clk);
         res_valid_in = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (stray_cnt !== 8'd3) begin
         errors++;
         $display("FAIL stray_idle got %0d expected 3", stray_cnt);
      end
      ch_req = 4'b0010;
      frm_q.push_back('{1, 8});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ch_grant !== '0) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL grant_bound ch1 never granted");
      end
      repeat (40) @(negedge clk);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_start_pos = 8'd77; res_valid_in = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; res_valid_in = 1'b0;
      checks++;
      if (start_cmp_position !== 8'd8 || stray_cnt !== 8'd4) begin
         errors++;
         $display("FAIL mid_frame scp=%0d stray=%0d expected 8 4", start_cmp_position, stray_cnt);
      end
      frm_q.push_back('{1, 77});
      wait_wait_res();
      send_res(1, 5, 32'h0000_0005);
      wait_wait_res();
      ch_req = '0;
      send_res(1, 6, 32'h0000_0006);
      res_valid_in = 1'b1;
      repeat (260) @(negedge clk);
      res_valid_in = 1'b0;
      @(negedge clk);
      checks++;
      if (stray_cnt !== 8'd255) begin
         errors++;
         $display("FAIL stray_saturate got %0d expected 255", stray_cnt);
      end
   endtask

   task automatic test_fft_ready();
      fft_ready = 1'b0;
      ch_req = 4'b1000;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ch_grant !== '0) begin
         errors++;
         $display("FAIL no_ready busy=%0b grant=%b expected 0 0", busy, ch_grant);
      end
      fft_ready = 1'b1;
      frm_q.push_back('{3, 8});
      @(negedge clk);
      checks++;
      if (ch_grant !== 4'b1000) begin
         errors++;
         $display("FAIL ready_grant grant=%b expected 1000", ch_grant);
      end
      wait_wait_res();
      ch_req = '0;
      send_res(3, 200, 32'hC000_0000);
   endtask

   task automatic test_reset_mid_stream();
      bit ok = 0;
      ch_req = 4'b0100;
      frm_q.push_back('{2, 8});
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ch_grant !== '0 && buf_rd_addr === 8'd100) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL addr100_bound never reached");
      end
      rst_n = 1'b0; ch_req = '0;
      #1;
      checks++;
      if ({ch_grant, ch_done, buf_rd_en, buf_rd_addr, fft_in_valid, fft_in_last, frame_ch,
           res_valid, busy, stray_cnt} !== '0 || start_cmp_position !== 8'd8) begin
         errors++;
         $display("FAIL mid_reset grant=%b rd=%0b addr=%0d busy=%0b scp=%0d expected 0 0 0 0 8",
                  ch_grant, buf_rd_en, buf_rd_addr, busy, start_cmp_position);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ch_req = 4'b1000;
      frm_q.push_back('{3, 8});
      wait_wait_res();
      ch_req = '0;
      send_res(3, 1, 32'h0000_0001);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_stray_and_cfg();
      test_fft_ready();
      test_reset_mid_stream();
      repeat (5) @(negedge clk);
      checks++;
      if (frm_q.size() != 0 || res_q.size() != 0) begin
         errors++;
         $display("FAIL leftover frames=%0d results=%0d expected 0 0", frm_q.size(), res_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
